// File: rtl/conv_mxfptobf16_pkg.sv
// Shared constants, FSM state type and element bias helper for the MX->BF16 decoder.
package conv_mxfptobf16_pkg;

  localparam int          BF16_BIAS = 127;
  localparam logic [14:0] BF16_QNAN = 15'h7FC0;
  localparam logic [14:0] BF16_INF  = 15'h7F80;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int elem_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/conv_mxfptobf16_if.sv
// Block-in / beat-out handshake bundle for the MX->BF16 decoder.
interface conv_mxfptobf16_if #(
  parameter int bit_width = 6,
  parameter int k         = 32,
  parameter int lanes     = 8
);
  logic [bit_width*k-1:0] i_mx_vec;
  logic [7:0]             i_mx_exp;
  logic                   i_valid;
  logic                   o_ready;
  logic [16*lanes-1:0]    o_bf16_vec;
  logic                   o_valid;
  logic                   o_last;
  logic                   i_ready;

  modport master (
    output i_mx_vec, i_mx_exp, i_valid, i_ready,
    input  o_ready, o_bf16_vec, o_valid, o_last
  );

  modport slave (
    input  i_mx_vec, i_mx_exp, i_valid, i_ready,
    output o_ready, o_bf16_vec, o_valid, o_last
  );
endinterface

// File: rtl/conv_mxfptobf16_elem.sv
// Combinational decoder: one MX element plus shared E8M0 scale -> one BF16 word.
// Exact conversion; results below the BF16 normal range flush to signed zero.
module conv_mxfptobf16_elem
  import conv_mxfptobf16_pkg::*;
#(
  parameter int exp_width = 3,
  parameter int man_width = 2
) (
  input  logic [exp_width+man_width:0] elem_i,
  input  logic [7:0]                   scale_i,
  output logic [15:0]                  bf16_o
);
  localparam int BIAS = elem_bias(exp_width);

  logic                 sgn;
  logic [exp_width-1:0] e;
  logic [man_width-1:0] m;
  logic signed [9:0]    x_s;
  logic signed [9:0]    exp_sum;
  logic [6:0]           mant;
  logic [2:0]           lead;

  assign {sgn, e, m} = elem_i;
  assign x_s         = {2'b00, scale_i};

  // Exponent/mantissa reconstruction, then special-case priority selection
  always_comb begin
    lead = '0;
    for (int i = 0; i < man_width; i++) begin
      if (m[i]) lead = 3'(i);
    end

    if (e != '0) begin
      exp_sum = x_s + 10'(e) - 10'(BIAS);
      mant    = 7'(7'(m) << (7 - man_width));
    end else begin
      // Element subnormal: renormalise on the leading one, dropping it as the hidden bit
      exp_sum = x_s - 10'(BIAS + man_width - 1) + 10'(lead);
      mant    = 7'(7'(m) << (7 - int'(lead)));
    end

    if (scale_i == 8'hFF)                bf16_o = {sgn, BF16_QNAN};
    else if (e == '0 && m == '0)         bf16_o = {sgn, 15'h0};
    else if (exp_sum >= 10'sd255)        bf16_o = {sgn, BF16_INF};
    else if (exp_sum <= 10'sd0)          bf16_o = {sgn, 15'h0};
    else                                 bf16_o = {sgn, exp_sum[7:0], mant};
  end
endmodule

// File: rtl/conv_mxfptobf16.sv
// MX block -> BF16 beat streamer: accepts a whole block in one handshake, then
// emits k/lanes beats of lanes decoded words. Zero-bubble block chaining.
module conv_mxfptobf16
  import conv_mxfptobf16_pkg::*;
#(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  parameter int bit_width = 1 + exp_width + man_width,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  conv_mxfptobf16_if.slave  bus
);
  localparam int BEATS   = k / lanes;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLICE_W = lanes * bit_width;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [bit_width*k-1:0] vec_q;
  logic [7:0]             scale_q;
  logic [SLICE_W-1:0]     slice;
  logic [16*lanes-1:0]    bf16;
  logic                   last;
  logic                   load;

  // FSM register and beat counter; reset drops any block in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Block buffer: written on accept only, contents irrelevant while idle
  always_ff @(posedge i_clk) begin
    if (load) begin
      vec_q   <= bus.i_mx_vec;
      scale_q <= bus.i_mx_exp;
    end
  end

  // Handshake outputs and next-state; last-beat handshake may reload in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last        = (state_q == ST_SEND) && (cnt_q == CNT_W'(BEATS - 1));
    bus.o_valid = (state_q == ST_SEND);
    bus.o_last  = last;
    bus.o_ready = (state_q == ST_IDLE) || (last && bus.i_ready);
    load        = bus.i_valid && bus.o_ready;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        if (bus.i_ready) begin
          if (last) begin
            cnt_d   = '0;
            state_d = load ? ST_SEND : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign slice = vec_q[int'(cnt_q)*SLICE_W +: SLICE_W];

  for (genvar j = 0; j < lanes; j++) begin : g_lane
    conv_mxfptobf16_elem #(
      .exp_width(exp_width),
      .man_width(man_width)
    ) u_elem (
      .elem_i (slice[j*bit_width +: bit_width]),
      .scale_i(scale_q),
      .bf16_o (bf16[j*16 +: 16])
    );
  end

  assign bus.o_bf16_vec = bf16;
endmodule

// File: tb/tb_conv_mxfptobf16.sv
module tb_conv_mxfptobf16;
  localparam int EW = 3;
  localparam int MW = 2;
  localparam int BW = 1 + EW + MW;
  localparam int K  = 32;
  localparam int LN = 8;
  localparam int EB = (1 << (EW - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [127:0] cap_data [4];
  logic         cap_last [4];
  int           cap_got;

  conv_mxfptobf16_if #(.bit_width(BW), .k(K), .lanes(LN)) bus ();

  conv_mxfptobf16 #(
    .exp_width(EW), .man_width(MW), .bit_width(BW), .k(K), .lanes(LN)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: element as integer significand n times 2^sh, scaled by 2^(X-127),
  // then renormalised to BF16 from the integer's MSB.
  function automatic logic [15:0] model_elem(input logic [BW-1:0] el, input logic [7:0] x);
    int s, e, m, n, sh, q, ebf, frac;
    s = int'(el[BW-1]);
    e = int'(el[BW-2:MW]);
    m = int'(el[MW-1:0]);
    if (x == 8'hFF) return {s[0], 15'h7FC0};
    n = (e == 0) ? m : m + (1 << MW);
    if (n == 0) return {s[0], 15'h0};
    sh = ((e == 0) ? 1 : e) - EB - MW;
    q = 0;
    for (int i = 0; i < 16; i++) if (n >= (1 << i)) q = i;
    ebf = q + sh + int'(x);
    if (ebf >= 255) return {s[0], 15'h7F80};
    if (ebf <= 0) return {s[0], 15'h0};
    frac = (n - (1 << q)) << (7 - q);
    return {s[0], ebf[7:0], frac[6:0]};
  endfunction

  function automatic logic [127:0] model_beat(input logic [BW*K-1:0] v, input logic [7:0] x, input int b);
    logic [127:0] r;
    for (int j = 0; j < LN; j++) r[j*16 +: 16] = model_elem(v[(b*LN + j)*BW +: BW], x);
    return r;
  endfunction

  function automatic logic [BW*K-1:0] rand_vec();
    logic [BW*K-1:0] v;
    for (int i = 0; i < BW*K/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Offer one block and wait for it to be taken; returns at posedge+1 after the accept.
  task automatic drive_block(input logic [BW*K-1:0] v, input logic [7:0] x);
    int t;
    t = 0;
    @(negedge clk);
    bus.i_mx_vec = v;
    bus.i_mx_exp = x;
    bus.i_valid  = 1'b1;
    bus.i_ready  = 1'b0;
    #1;
    while (!bus.o_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.o_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout o_ready=%b required 1", bus.o_ready);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Drain up to 4 beats with random backpressure (bp percent of cycles not ready).
  task automatic collect(input int bp);
    int t;
    t = 0;
    cap_got = 0;
    while (cap_got < 4 && t < 200) begin
      bus.i_ready = ($urandom_range(99) >= bp);
      #1;
      if (bus.o_valid && bus.i_ready) begin
        cap_data[cap_got] = bus.o_bf16_vec;
        cap_last[cap_got] = bus.o_last;
        cap_got++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b required 0", bus.o_valid); end
    n_checks++;
    if (bus.o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b required 0", bus.o_last); end
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b required 1", bus.o_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [BW-1:0] els  [8];
    logic [7:0]    xs   [8];
    logic [15:0]   exps [8];
    logic [BW*K-1:0] v;
    els[0] = 6'b0_011_00; xs[0] = 8'd127; exps[0] = 16'h3F80;
    els[1] = 6'b1_100_10; xs[1] = 8'd127; exps[1] = 16'hC040;
    els[2] = 6'b0_000_01; xs[2] = 8'd127; exps[2] = 16'h3D80;
    els[3] = 6'b0_000_11; xs[3] = 8'd127; exps[3] = 16'h3E40;
    els[4] = 6'b1_011_00; xs[4] = 8'hFF;  exps[4] = 16'hFFC0;
    els[5] = 6'b0_111_11; xs[5] = 8'd254; exps[5] = 16'h7F80;
    els[6] = 6'b0_001_00; xs[6] = 8'd0;   exps[6] = 16'h0000;
    els[7] = 6'b1_000_00; xs[7] = 8'd127; exps[7] = 16'h8000;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < K; i++) v[i*BW +: BW] = els[c];
      drive_block(v, xs[c]);
      collect(0);
      n_checks++;
      if (cap_got !== 4) begin n_fail++; $display("FAIL dir_beats case %0d got %0d required 4", c, cap_got); end
      for (int b = 0; b < cap_got; b++) begin
        n_checks++;
        if (cap_data[b][(b*3 % LN)*16 +: 16] !== exps[c]) begin
          n_fail++;
          $display("FAIL dir_value case %0d beat %0d got %h required %h", c, b, cap_data[b][(b*3 % LN)*16 +: 16], exps[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [BW*K-1:0] v;
    logic [7:0]      x;
    int              r;
    for (int n = 0; n < 24; n++) begin
      v = rand_vec();
      r = $urandom_range(9);
      case (r)
        0: x = 8'hFF;
        1: x = 8'd0;
        2: x = 8'd254;
        3: x = 8'($urandom_range(1, 20));
        default: x = 8'($urandom_range(100, 150));
      endcase
      drive_block(v, x);
      collect(35);
      n_checks++;
      if (cap_got !== 4) begin n_fail++; $display("FAIL rnd_beats blk %0d got %0d required 4", n, cap_got); end
      for (int b = 0; b < cap_got; b++) begin
        n_checks++;
        if (cap_data[b] !== model_beat(v, x, b)) begin
          n_fail++;
          $display("FAIL rnd_data blk %0d beat %0d x=%h got %h required %h", n, b, x, cap_data[b], model_beat(v, x, b));
        end
        n_checks++;
        if (cap_last[b] !== (b == 3)) begin
          n_fail++;
          $display("FAIL rnd_last blk %0d beat %0d got %b required %b", n, b, cap_last[b], (b == 3));
        end
      end
      #1;
      n_checks++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle blk %0d o_valid got %b required 0", n, bus.o_valid); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [BW*K-1:0] v;
    logic [7:0]      x;
    logic [127:0]    held;
    int              got, t;
    v = rand_vec();
    x = 8'd127;
    drive_block(v, x);
    got = 0;
    t   = 0;
    while (got < 2 && t < 20) begin
      bus.i_ready = 1'b1;
      #1;
      if (bus.o_valid && bus.i_ready) got++;
      @(posedge clk);
      #1;
      t++;
    end
    bus.i_ready = 1'b0;
    #1;
    held = bus.o_bf16_vec;
    n_checks++;
    if (held !== model_beat(v, x, 2)) begin n_fail++; $display("FAIL bp_beat2 got %h required %h", held, model_beat(v, x, 2)); end
    @(posedge clk);
    #1;
    repeat (5) begin
      #1;
      n_checks++;
      if (bus.o_bf16_vec !== held) begin n_fail++; $display("FAIL bp_stable got %h required %h", bus.o_bf16_vec, held); end
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ctrl valid/ready/last got %b%b%b required 100", bus.o_valid, bus.o_ready, bus.o_last);
      end
      @(posedge clk);
      #1;
    end
    t = 0;
    while (t < 20) begin
      bus.i_ready = 1'b1;
      #1;
      if (bus.o_valid && bus.i_ready) begin
        n_checks++;
        if (bus.o_bf16_vec !== model_beat(v, x, got)) begin
          n_fail++;
          $display("FAIL bp_drain beat %0d got %h required %h", got, bus.o_bf16_vec, model_beat(v, x, got));
        end
        got++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.i_ready = 1'b0;
    n_checks++;
    if (got !== 4) begin n_fail++; $display("FAIL bp_count got %0d required 4", got); end
  endtask

  task automatic test_back_to_back();
    logic [BW*K-1:0] va, vb;
    logic [7:0]      xa, xb;
    logic [127:0]    exp_beat;
    int              sent, b;
    va = rand_vec();
    vb = rand_vec();
    xa = 8'd120;
    xb = 8'd131;
    @(posedge clk);
    #1;
    bus.i_mx_vec = va;
    bus.i_mx_exp = xa;
    bus.i_valid  = 1'b1;
    bus.i_ready  = 1'b1;
    sent = 0;
    b    = 0;
    for (int c = 0; c < 14 && b < 8; c++) begin
      #1;
      if (bus.o_valid) begin
        exp_beat = (b < 4) ? model_beat(va, xa, b) : model_beat(vb, xb, b - 4);
        n_checks++;
        if (bus.o_bf16_vec !== exp_beat) begin
          n_fail++;
          $display("FAIL b2b_data beat %0d got %h required %h", b, bus.o_bf16_vec, exp_beat);
        end
        n_checks++;
        if (bus.o_last !== (b == 3 || b == 7)) begin
          n_fail++;
          $display("FAIL b2b_last beat %0d got %b required %b", b, bus.o_last, (b == 3 || b == 7));
        end
        b++;
      end else if (b > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_bubble after beat %0d o_valid got 0 required 1", b);
      end
      if (bus.i_valid && bus.o_ready) sent++;
      @(posedge clk);
      #1;
      if (sent == 1) begin
        bus.i_mx_vec = vb;
        bus.i_mx_exp = xb;
      end
      if (sent == 2) bus.i_valid = 1'b0;
    end
    n_checks++;
    if (b !== 8) begin n_fail++; $display("FAIL b2b_count got %0d required 8", b); end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle o_valid got %b required 0", bus.o_valid); end
  endtask

  task automatic test_reset_mid_send();
    logic [BW*K-1:0] va, vb;
    logic [7:0]      xb;
    va = rand_vec();
    vb = rand_vec();
    xb = 8'd140;
    drive_block(va, 8'd127);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b required 0", bus.o_valid); end
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b required 1", bus.o_ready); end
    drive_block(vb, xb);
    collect(20);
    n_checks++;
    if (cap_got !== 4) begin n_fail++; $display("FAIL rstmid_beats got %0d required 4", cap_got); end
    for (int b = 0; b < cap_got; b++) begin
      n_checks++;
      if (cap_data[b] !== model_beat(vb, xb, b)) begin
        n_fail++;
        $display("FAIL rstmid_data beat %0d got %h required %h", b, cap_data[b], model_beat(vb, xb, b));
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_mx_vec = '0;
    bus.i_mx_exp = '0;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
